// File: rtl/writeback_stage.sv
// Write-back stage: merges load responses and ALU results into one register-file write per cycle.
// Loads always win; ALU results that collide with a load wait in a small in-order queue.
module writeback_stage #(
    parameter int unsigned QUEUE_DEPTH = 2,
    parameter int unsigned XLEN        = 32
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           alu_valid_i,
    output logic                           alu_ready_o,
    input  logic                           alu_reg_write_i,
    input  logic [4:0]                     alu_rd_i,
    input  logic [XLEN-1:0]                alu_result_i,
    input  logic                           ld_valid_i,
    input  logic [4:0]                     ld_rd_i,
    input  logic [2:0]                     ld_funct3_i,
    input  logic [1:0]                     ld_addr_low_i,
    input  logic [XLEN-1:0]                ld_data_i,
    output logic                           reg_write_wb_o,
    output logic [4:0]                     reg_rd_wb_o,
    output logic [XLEN-1:0]                reg_rd_data_wb_o,
    output logic                           load_fault_o,
    output logic [$clog2(QUEUE_DEPTH):0]   queue_count_o
);

    localparam int unsigned PW = $clog2(QUEUE_DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [PW-1:0]   head_q, tail_q;
    logic [CW-1:0]   count_q;
    logic [4:0]      q_rd   [QUEUE_DEPTH];
    logic [XLEN-1:0] q_data [QUEUE_DEPTH];

    logic            alu_take, deq, direct, enq;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] ld_ext;
    logic            ld_fault;
    logic            wr_d, fault_d;
    logic [4:0]      rd_d;
    logic [XLEN-1:0] data_d;

    assign alu_ready_o   = count_q < CW'(QUEUE_DEPTH);
    assign queue_count_o = count_q;

    // Writes without reg_write were never scoreboarded, so they are consumed silently.
    assign alu_take = alu_valid_i & alu_ready_o & alu_reg_write_i;
    assign deq      = !ld_valid_i && (count_q != '0);
    assign direct   = !ld_valid_i && (count_q == '0) && alu_take;
    assign enq      = alu_take && !direct;

    always_comb begin
        ld_byte  = 8'(ld_data_i >> {ld_addr_low_i, 3'b000});
        ld_half  = 16'(ld_data_i >> {ld_addr_low_i[1], 4'b0000});
        ld_ext   = '0;
        ld_fault = 1'b0;
        unique case (ld_funct3_i)
            3'b000: ld_ext = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            3'b100: ld_ext = {{(XLEN-8){1'b0}}, ld_byte};
            3'b001: begin
                ld_ext   = {{(XLEN-16){ld_half[15]}}, ld_half};
                ld_fault = ld_addr_low_i[0];
            end
            3'b101: begin
                ld_ext   = {{(XLEN-16){1'b0}}, ld_half};
                ld_fault = ld_addr_low_i[0];
            end
            3'b010: begin
                ld_ext   = ld_data_i;
                ld_fault = (ld_addr_low_i != 2'b00);
            end
            default: ld_fault = 1'b1;
        endcase
        // A faulting load still writes (zero) so the pending-write counter drains.
        if (ld_fault) ld_ext = '0;
    end

    always_comb begin
        wr_d    = 1'b0;
        rd_d    = '0;
        data_d  = '0;
        fault_d = 1'b0;
        if (ld_valid_i) begin
            wr_d    = 1'b1;
            rd_d    = ld_rd_i;
            data_d  = ld_ext;
            fault_d = ld_fault;
        end else if (deq) begin
            wr_d   = 1'b1;
            rd_d   = q_rd[head_q];
            data_d = q_data[head_q];
        end else if (direct) begin
            wr_d   = 1'b1;
            rd_d   = alu_rd_i;
            data_d = alu_result_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            head_q           <= '0;
            tail_q           <= '0;
            count_q          <= '0;
            reg_write_wb_o   <= 1'b0;
            reg_rd_wb_o      <= '0;
            reg_rd_data_wb_o <= '0;
            load_fault_o     <= 1'b0;
        end else begin
            if (deq) head_q <= head_q + PW'(1);
            if (enq) tail_q <= tail_q + PW'(1);
            count_q          <= count_q + CW'(enq) - CW'(deq);
            reg_write_wb_o   <= wr_d;
            reg_rd_wb_o      <= rd_d;
            reg_rd_data_wb_o <= data_d;
            load_fault_o     <= fault_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq) begin
            q_rd[tail_q]   <= alu_rd_i;
            q_data[tail_q] <= alu_result_i;
        end
    end

endmodule
